pc_seq_unit: RTL and testbench

- Parametrised successor to the 2-bit-opcode program counter.
- Adds:
  - configurable PC width
  - relative branches
  - call/return through an internal return-address stack (LIFO)
  - a stall enable
  - stack over/underflow detection
- Sits between the instruction decoder (opcode, target, offset) and instruction memory (O_pc as fetch address).
- Updates on the falling edge of I_clk, so the PC is stable for rising-edge fetch/decode logic.

---
 rtl/pc_seq_pkg.sv | 15 +
 rtl/pc_ret_stack.sv | 65 ++++++
 rtl/pc_seq_unit.sv | 114 +++++++++++
 tb/tb_pc_seq_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared opcode encodings for the program-counter sequencer and its return stack.
package pc_seq_pkg;

  localparam int unsigned PC_OP_W = 3;

  localparam logic [PC_OP_W-1:0] OP_HOLD = 3'b000;
  localparam logic [PC_OP_W-1:0] OP_INC  = 3'b001;
  localparam logic [PC_OP_W-1:0] OP_JMP  = 3'b010;
  localparam logic [PC_OP_W-1:0] OP_BR   = 3'b011;
  localparam logic [PC_OP_W-1:0] OP_CALL = 3'b100;
  localparam logic [PC_OP_W-1:0] OP_RET  = 3'b101;
  localparam logic [PC_OP_W-1:0] OP_RST  = 3'b110;
  localparam logic [PC_OP_W-1:0] OP_RSVD = 3'b111;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO, updated on the falling clock edge. Push-when-full and
// pop-when-empty are silently ignored; clear has priority over both.
module pc_ret_stack #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            clear_i,
  input  logic [PC_W-1:0] data_i,
  output logic [PC_W-1:0] top_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [CntW-1:0] count_q, count_d;
  logic [IdxW-1:0] wr_idx, rd_idx;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;

  // Index truncation is harmless: writes are blocked when full, reads unused when empty.
  assign wr_idx = IdxW'(count_q);
  assign rd_idx = IdxW'(count_q - CntW'(1));
  assign top_o  = mem_q[rd_idx];

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (do_push) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are valid.
  always_ff @(negedge clk_i) begin
    if (do_push) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer with relative branch, call/return stack and sticky
// stack-fault flag. Define PC_TRAP_EN to redirect faults to TRAP_VEC.
module pc_seq_unit
  import pc_seq_pkg::*;
#(
  parameter int unsigned     PC_W      = 16,
  parameter int unsigned     OFF_W     = 8,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = {PC_W{1'b1}}
) (
  input  logic                         I_clk,
  input  logic                         I_rst_n,
  input  logic                         I_en,
  input  logic [PC_OP_W-1:0]           I_opcode,
  input  logic [PC_W-1:0]              I_target,
  input  logic [OFF_W-1:0]             I_offset,
  output logic [PC_W-1:0]              O_pc,
  output logic [$clog2(DEPTH+1)-1:0]   O_sp,
  output logic                         O_stack_full,
  output logic                         O_stack_empty,
  output logic                         O_err
);

`ifdef PC_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic [PC_W-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic [PC_W-1:0] pc_inc, off_ext, stk_top;
  logic            push, pop, clear, fault;
  logic            stk_full, stk_empty;

  assign pc_inc  = pc_q + PC_W'(1);
  assign off_ext = PC_W'($signed(I_offset));

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
    fault = 1'b0;
    if (I_en) begin
      case (I_opcode)
        OP_INC: pc_d = pc_inc;
        OP_JMP: pc_d = I_target;
        OP_BR:  pc_d = pc_q + off_ext;
        OP_CALL: begin
          pc_d  = I_target;
          push  = !stk_full;
          fault = stk_full;
        end
        OP_RET: begin
          if (stk_empty) begin
            pc_d  = pc_inc;
            fault = 1'b1;
          end else begin
            pc_d = stk_top;
            pop  = 1'b1;
          end
        end
        OP_RST: begin
          pc_d  = RESET_VEC;
          err_d = 1'b0;
          clear = 1'b1;
        end
        OP_RSVD: fault = 1'b1;
        default: ;
      endcase
      if (fault) begin
        err_d = 1'b1;
        if (TrapEn) begin
          pc_d = TRAP_VEC;
        end
      end
    end
  end

  always_ff @(negedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pc_q  <= RESET_VEC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  pc_ret_stack #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk_i   (I_clk),
    .rst_ni  (I_rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (clear),
    .data_i  (pc_inc),
    .top_o   (stk_top),
    .count_o (O_sp),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  assign O_pc          = pc_q;
  assign O_err         = err_q;
  assign O_stack_full  = stk_full;
  assign O_stack_empty = stk_empty;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit (PC_W=16, OFF_W=8, DEPTH=4, RESET_VEC=0).
module tb_pc_seq_unit;

  localparam logic [15:0] TrapVec = 16'hFFFF;
`ifdef PC_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        I_clk;
  logic        I_rst_n;
  logic        I_en;
  logic [2:0]  I_opcode;
  logic [15:0] I_target;
  logic [7:0]  I_offset;
  logic [15:0] O_pc;
  logic [2:0]  O_sp;
  logic        O_stack_full;
  logic        O_stack_empty;
  logic        O_err;

  int total = 0;
  int bad   = 0;

  pc_seq_unit #(
    .PC_W      (16),
    .OFF_W     (8),
    .DEPTH     (4),
    .RESET_VEC (16'h0000),
    .TRAP_VEC  (TrapVec)
  ) dut (
    .I_clk         (I_clk),
    .I_rst_n       (I_rst_n),
    .I_en          (I_en),
    .I_opcode      (I_opcode),
    .I_target      (I_target),
    .I_offset      (I_offset),
    .O_pc          (O_pc),
    .O_sp          (O_sp),
    .O_stack_full  (O_stack_full),
    .O_stack_empty (O_stack_empty),
    .O_err         (O_err)
  );

  initial begin
    I_clk = 1'b1;
    forever #5 I_clk = ~I_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one opcode across a falling edge, then return just after the next rising edge.
  task automatic op(input logic [2:0] o, input logic [15:0] t = 16'h0, input logic [7:0] f = 8'h0);
    I_opcode = o;
    I_target = t;
    I_offset = f;
    @(negedge I_clk);
    @(posedge I_clk);
    #1;
  endtask

  task automatic state(input string tag, input logic [15:0] pc, input logic [2:0] sp,
                       input logic err);
    chk({tag, ".pc"}, 32'(O_pc), 32'(pc));
    chk({tag, ".sp"}, 32'(O_sp), 32'(sp));
    chk({tag, ".err"}, 32'(O_err), 32'(err));
  endtask

  initial begin
    I_rst_n  = 1'b0;
    I_en     = 1'b1;
    I_opcode = 3'b000;
    I_target = '0;
    I_offset = '0;
    #1;
    state("por", 16'h0, 3'd0, 1'b0);
    chk("por.empty", 32'(O_stack_empty), 32'd1);
    @(posedge I_clk);
    #1;
    I_rst_n = 1'b1;

    // Dirty all state, then reset asynchronously mid-cycle.
    op(3'b111);
    chk("rsvd0.err", 32'(O_err), 32'd1);
    op(3'b100, 16'h0042);
    state("pre_rst", 16'h0042, 3'd1, 1'b1);
    #2;
    I_rst_n = 1'b0;
    #1;
    state("async_rst", 16'h0, 3'd0, 1'b0);
    @(posedge I_clk);
    #1;
    I_rst_n = 1'b1;
    op(3'b001);
    op(3'b001);
    op(3'b001);
    chk("inc3.pc", 32'(O_pc), 32'h3);
    op(3'b000);
    chk("hold.pc", 32'(O_pc), 32'h3);

    // Branches and wrap.
    op(3'b010, 16'h0010);
    op(3'b011, 16'h0, 8'hF8);
    chk("br_neg.pc", 32'(O_pc), 32'h0008);
    op(3'b011, 16'h0, 8'h7F);
    chk("br_pos.pc", 32'(O_pc), 32'h0087);
    op(3'b010, 16'h0000);
    op(3'b011, 16'h0, 8'hF8);
    chk("br_wrap.pc", 32'(O_pc), 32'hFFF8);
    op(3'b010, 16'hFFFF);
    op(3'b001);
    chk("inc_wrap.pc", 32'(O_pc), 32'h0000);

    // Nested call/return.
    op(3'b010, 16'h0010);
    op(3'b100, 16'h0100);
    state("call1", 16'h0100, 3'd1, 1'b0);
    op(3'b100, 16'h0200);
    state("call2", 16'h0200, 3'd2, 1'b0);
    op(3'b101);
    state("ret1", 16'h0101, 3'd1, 1'b0);
    op(3'b101);
    state("ret2", 16'h0011, 3'd0, 1'b0);
    chk("ret2.empty", 32'(O_stack_empty), 32'd1);

    // Overflow: four good calls then one into a full stack.
    for (int i = 0; i < 4; i++) op(3'b100, 16'h1000 + 16'(i));
    state("call4", 16'h1003, 3'd4, 1'b0);
    chk("call4.full", 32'(O_stack_full), 32'd1);
    op(3'b100, 16'h1004);
    state("ovf", Trap ? TrapVec : 16'h1004, 3'd4, 1'b1);
    op(3'b101);
    state("ovf_ret", 16'h1003, 3'd3, 1'b1);

    // Soft reset, then underflow.
    op(3'b110);
    state("soft_rst", 16'h0, 3'd0, 1'b0);
    op(3'b101);
    state("unf", Trap ? TrapVec : 16'h0001, 3'd0, 1'b1);

    // Stall: CALL with enable low must change nothing.
    op(3'b110);
    op(3'b010, 16'h0020);
    I_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      op(3'b100, 16'h0300);
      state($sformatf("stall%0d", i), 16'h0020, 3'd0, 1'b0);
    end
    op(3'b111);
    chk("stall_rsvd.err", 32'(O_err), 32'd0);
    I_en = 1'b1;

    // Reserved opcode, sticky error, soft reset clears.
    op(3'b111);
    state("rsvd", Trap ? TrapVec : 16'h0020, 3'd0, 1'b1);
    op(3'b001);
    chk("sticky.err", 32'(O_err), 32'd1);
    op(3'b100, 16'h0055);
    op(3'b110);
    state("rst_op", 16'h0, 3'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
